// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame FIFO: buffers GMII receiver bytes speculatively,
// commits only good frames, and replays them on AXI4-Stream with backpressure.
module eth_rx_frame_fifo #(
  parameter int DEPTH   = 4096,
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       status_good_frame,
  output logic       status_bad_frame,
  output logic       status_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [10:0] LEN_SAT  = 11'(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} wr_state_t;

  wr_state_t   state;
  logic [AW:0] wr_cur, wr_commit, rd_ptr;
  logic [10:0] len;
  logic        drop_ovf;
  logic [8:0]  ram [DEPTH];

  logic full, wr_en;
  logic rd_vld, out_vld, load_out, rd_en;
  logic [8:0] rd_q, out_q;

  assign full  = (wr_cur - rd_ptr) == FULL_CNT;
  // len counts beats already written, so len < MAX_L admits this beat
  assign wr_en = s_axis_tvalid && !rst && (state != DROP) && !full && (len < MAX_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      wr_cur            <= '0;
      wr_commit         <= '0;
      len               <= '0;
      drop_ovf          <= 1'b0;
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
    end else begin
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
      if (s_axis_tvalid) begin
        len <= s_axis_tlast ? '0 : ((len == LEN_SAT) ? len : len + 11'd1);
        case (state)
          IDLE, ACTIVE: begin
            if (wr_en) begin
              if (s_axis_tlast) begin
                state <= IDLE;
                if ((len + 11'd1) >= MIN_L && !s_axis_tuser) begin
                  wr_cur            <= wr_cur + 1'b1;
                  wr_commit         <= wr_cur + 1'b1;
                  status_good_frame <= 1'b1;
                end else begin
                  wr_cur           <= wr_commit;
                  status_bad_frame <= 1'b1;
                end
              end else begin
                wr_cur <= wr_cur + 1'b1;
                state  <= ACTIVE;
              end
            end else if (s_axis_tlast) begin
              // beat that could not be stored also ends the frame: resolve now
              wr_cur           <= wr_commit;
              status_overflow  <= full;
              status_bad_frame <= !full;
              state            <= IDLE;
            end else begin
              drop_ovf <= full;
              state    <= DROP;
            end
          end
          DROP: begin
            if (s_axis_tlast) begin
              wr_cur           <= wr_commit;
              status_overflow  <= drop_ovf;
              status_bad_frame <= !drop_ovf;
              state            <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // read pipeline: RAM read register feeding the output register
  assign load_out = !out_vld || m_axis_tready;
  assign rd_en    = (rd_ptr != wr_commit) && (!rd_vld || load_out);

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_cur[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    if (rd_en) rd_q <= ram[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      rd_vld  <= 1'b0;
      out_vld <= 1'b0;
      out_q   <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      rd_vld <= rd_en || (rd_vld && !load_out);
      if (load_out) begin
        out_vld <= rd_vld;
        if (rd_vld) out_q <= rd_q;
      end
    end
  end

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_q[7:0];
  assign m_axis_tlast  = out_q[8];
endmodule
